// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        MEMW = 1'b1
    } hc_state_t;

    localparam int          RIDX_W_DEFAULT = 4;
    localparam int          CNT_W          = 3;
    localparam logic [15:0] NOP_INSTR      = 16'h0800;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and control outputs; master = pipeline, slave = controller.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int RIDX_W = RIDX_W_DEFAULT
);
    logic              hci_idex_memrd;
    logic [RIDX_W-1:0] hci_idex_rd;
    logic [RIDX_W-1:0] hci_id_rs;
    logic [RIDX_W-1:0] hci_id_rt;
    logic              hci_id_rs_used;
    logic              hci_id_rt_used;
    logic              hci_br_taken;
    logic              hci_exmem_imem;

    logic              hco_pc_en;
    logic              hco_ifid_en;
    logic              hco_ifid_nop;
    logic              hco_idex_bubble;
    logic              hco_br_commit;
    logic              hco_stall;

    modport master (
        output hci_idex_memrd, hci_idex_rd, hci_id_rs, hci_id_rt,
               hci_id_rs_used, hci_id_rt_used, hci_br_taken, hci_exmem_imem,
        input  hco_pc_en, hco_ifid_en, hco_ifid_nop, hco_idex_bubble,
               hco_br_commit, hco_stall
    );

    modport slave (
        input  hci_idex_memrd, hci_idex_rd, hci_id_rs, hci_id_rt,
               hci_id_rs_used, hci_id_rt_used, hci_br_taken, hci_exmem_imem,
        output hco_pc_en, hco_ifid_en, hco_ifid_nop, hco_idex_bubble,
               hco_br_commit, hco_stall
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: a load in ID/EX feeding a source read in ID.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int RIDX_W = RIDX_W_DEFAULT
) (
    input  logic              idex_memrd,
    input  logic [RIDX_W-1:0] idex_rd,
    input  logic [RIDX_W-1:0] id_rs,
    input  logic [RIDX_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    output logic              load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = id_rs_used && (id_rs == idex_rd);
    assign rt_hit   = id_rt_used && (id_rt == idex_rd);
    assign load_use = idex_memrd && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: structural imem stall, load-use bubble, branch commit.
// Optional macro HAZARD_CTRL_DELAY_SLOT_EN keeps the delay-slot fetch alive on a committed branch.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int RIDX_W   = RIDX_W_DEFAULT
) (
    input  logic         hci_clk,
    input  logic         hci_rst,
    hazard_ctrl_if.slave hif
);

    hc_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             struct_stall;

    logic pc_en;
    logic ifid_en;
    logic ifid_nop;
    logic idex_bubble;
    logic br_commit;
    logic stall;

    hazard_detect #(
        .RIDX_W (RIDX_W)
    ) u_detect (
        .idex_memrd (hif.hci_idex_memrd),
        .idex_rd    (hif.hci_idex_rd),
        .id_rs      (hif.hci_id_rs),
        .id_rt      (hif.hci_id_rt),
        .id_rs_used (hif.hci_id_rs_used),
        .id_rt_used (hif.hci_id_rt_used),
        .load_use   (load_use)
    );

    // The imem conflict blocks fetch in the very cycle it is seen, before MEMW is entered.
    assign struct_stall = (state == MEMW) || ((state == RUN) && hif.hci_exmem_imem);

    always_ff @(posedge hci_clk or negedge hci_rst) begin
        if (!hci_rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hif.hci_exmem_imem && (MEM_WAIT > 1)) begin
                        state <= MEMW;
                        cnt   <= CNT_W'(MEM_WAIT - 1);
                    end
                end
                MEMW: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_nop    = 1'b0;
        idex_bubble = 1'b0;
        br_commit   = 1'b0;
        stall       = 1'b0;
        if (!hci_rst) begin
            pc_en       = 1'b0;
            ifid_nop    = 1'b1;
            idex_bubble = 1'b1;
            stall       = 1'b1;
        end else if (struct_stall || load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            stall       = 1'b1;
        end else begin
            br_commit = hif.hci_br_taken;
`ifdef HAZARD_CTRL_DELAY_SLOT_EN
            ifid_nop  = 1'b0;
`else
            ifid_nop  = hif.hci_br_taken;
`endif
        end
    end

    assign hif.hco_pc_en       = pc_en;
    assign hif.hco_ifid_en     = ifid_en;
    assign hif.hco_ifid_nop    = ifid_nop;
    assign hif.hco_idex_bubble = idex_bubble;
    assign hif.hco_br_commit   = br_commit;
    assign hif.hco_stall       = stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MEM_WAIT=3.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int RIDX_W = 4;

    // Output vector order: {pc_en, ifid_en, ifid_nop, idex_bubble, br_commit, stall}
    localparam logic [5:0] OUT_RESET = 6'b011101;
    localparam logic [5:0] OUT_IDLE  = 6'b110000;
    localparam logic [5:0] OUT_STALL = 6'b000101;
`ifdef HAZARD_CTRL_DELAY_SLOT_EN
    localparam logic [5:0] OUT_BRANCH = 6'b110010;
`else
    localparam logic [5:0] OUT_BRANCH = 6'b111010;
`endif

    logic hci_clk;
    logic hci_rst;
    int   passed;
    int   checks;

    hazard_ctrl_if #(.RIDX_W(RIDX_W)) hif ();

    hazard_ctrl #(
        .MEM_WAIT (3),
        .RIDX_W   (RIDX_W)
    ) dut (
        .hci_clk (hci_clk),
        .hci_rst (hci_rst),
        .hif     (hif.slave)
    );

    initial hci_clk = 1'b0;
    always #5 hci_clk = ~hci_clk;

    task automatic applyStimulus(
        input logic              memrd,
        input logic [RIDX_W-1:0] rd,
        input logic [RIDX_W-1:0] rs,
        input logic [RIDX_W-1:0] rt,
        input logic              rs_used,
        input logic              rt_used,
        input logic              br,
        input logic              imem
    );
        @(negedge hci_clk);
        hif.hci_idex_memrd = memrd;
        hif.hci_idex_rd    = rd;
        hif.hci_id_rs      = rs;
        hif.hci_id_rt      = rt;
        hif.hci_id_rs_used = rs_used;
        hif.hci_id_rt_used = rt_used;
        hif.hci_br_taken   = br;
        hif.hci_exmem_imem = imem;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] expected);
        logic [5:0] observed;
        observed = {hif.hco_pc_en, hif.hco_ifid_en, hif.hco_ifid_nop,
                    hif.hco_idex_bubble, hif.hco_br_commit, hif.hco_stall};
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    endtask

    task automatic checkState(input string tag, input hc_state_t expected);
        hc_state_t observed;
        observed = dut.state;
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed state %0d expected %0d", tag, observed, expected);
    endtask

    initial begin
        passed = 0;
        checks = 0;
        hci_rst = 1'b0;
        hif.hci_idex_memrd = 1'b0;
        hif.hci_idex_rd    = '0;
        hif.hci_id_rs      = '0;
        hif.hci_id_rt      = '0;
        hif.hci_id_rs_used = 1'b0;
        hif.hci_id_rt_used = 1'b0;
        hif.hci_br_taken   = 1'b0;
        hif.hci_exmem_imem = 1'b0;

        // Reset holds outputs at their safe values even with a branch and conflict requested.
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_outputs", OUT_RESET);
        checkState("reset_state", RUN);

        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hci_rst = 1'b1;
        #1;
        checkOutput("idle_after_reset", OUT_IDLE);

        applyStimulus(1'b1, 4'd2, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_rs", OUT_STALL);
        applyStimulus(1'b0, 4'd0, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_rs_clear", OUT_IDLE);
        checkState("lu_no_state_change", RUN);

        applyStimulus(1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_rt", OUT_STALL);
        applyStimulus(1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rt_unused", OUT_IDLE);
        applyStimulus(1'b0, 4'd6, 4'd6, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("no_load", OUT_IDLE);

        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("branch_free", OUT_BRANCH);

        applyStimulus(1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("branch_with_lu", OUT_STALL);
        applyStimulus(1'b0, 4'd0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("branch_after_lu", OUT_BRANCH);

        // Imem conflict: three stall cycles, two of them in MEMW; new requests ignored there.
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("memw_c0", OUT_STALL);
        checkState("memw_c0_state", RUN);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("memw_c1_branch_blocked", OUT_STALL);
        checkState("memw_c1_state", MEMW);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("memw_c2", OUT_STALL);
        checkState("memw_c2_state", MEMW);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("memw_done", OUT_IDLE);
        checkState("memw_done_state", RUN);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("branch_after_memw", OUT_BRANCH);

        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_memw_c0", OUT_STALL);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkState("rst_memw_c1_state", MEMW);
        @(negedge hci_clk);
        hci_rst = 1'b0;
        #1;
        checkOutput("rst_mid_memw", OUT_RESET);
        checkState("rst_mid_memw_state", RUN);
        @(negedge hci_clk);
        hci_rst = 1'b1;
        #1;
        checkOutput("release_no_stall", OUT_IDLE);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("release_no_stall_2", OUT_IDLE);
        checkState("release_state", RUN);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, meaning cycles fetch is blocked per instruction-memory data access (legal 1..7).
REQ-002 SHALL have parameter RIDX_W, default 4, meaning register-index width.
REQ-003 SHALL have ports: hci_clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have ports: hci_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: hci_idex_memrd  in  1  instruction in ID/EX is a load.
REQ-006 SHALL have ports: hci_idex_rd  in  RIDX_W  destination register of ID/EX instruction.
REQ-007 SHALL have ports: hci_id_rs / hci_id_rt  in  RIDX_W each  source registers of ID instruction.
REQ-008 SHALL have ports: hci_id_rs_used / hci_id_rt_used  in  1 each  source actually read.
REQ-009 SHALL have ports: hci_br_taken  in  1  ID resolves a taken branch/jump.
REQ-010 SHALL have ports: hci_exmem_imem  in  1  EX/MEM instruction accesses instruction memory (structural conflict).
REQ-011 SHALL have ports: hco_pc_en  out  1  PC register load enable.
REQ-012 SHALL have ports: hco_ifid_en  out  1  IF/ID register load enable.
REQ-013 SHALL have ports: hco_ifid_nop  out  1  IF instruction mux selects NOP.
REQ-014 SHALL have ports: hco_idex_bubble  out  1  ID/EX loads NOP control word.
REQ-015 SHALL have ports: hco_br_commit  out  1  PC mux may take branch target.
REQ-016 SHALL have ports: hco_stall  out  1  any stall active (status).

Function
REQ-017 SHALL implement states RUN and MEMW with a down-counter cnt of 3 bits.
REQ-018 SHALL compute load-use hazard LU = hci_idex_memrd and ((rs_used and rs==rd) or (rt_used and rt==rd)).
REQ-019 SHALL define structural stall ST = (state==MEMW) or (state==RUN and hci_exmem_imem).
REQ-020 SHALL, when ST or LU, drive pc_en=0, ifid_en=0, ifid_nop=0, idex_bubble=1, br_commit=0, stall=1 in the same cycle (zero latency, Mealy).
REQ-021 SHALL, when neither ST nor LU, drive pc_en=1, ifid_en=1, idex_bubble=0, stall=0, br_commit=hci_br_taken.
REQ-022 SHALL in RUN with hci_exmem_imem and MEM_WAIT>1 go to MEMW with cnt=MEM_WAIT-1; with MEM_WAIT==1 stay in RUN.
REQ-023 SHALL in MEMW decrement cnt each cycle and return to RUN on the edge where cnt==1; hci_exmem_imem ignored in MEMW.
REQ-024 SHALL give ST priority over LU and both priority over branch: a taken branch during stall is suppressed and re-evaluated when ID advances.
REQ-025 SHALL treat LU as purely combinational; it never changes state.

Reset
REQ-026 SHALL, while hci_rst=0, force state=RUN, cnt=0, pc_en=0, ifid_en=1, ifid_nop=1, idex_bubble=1, br_commit=0, stall=1.
REQ-027 SHALL, on reset assertion mid-MEMW, abandon the count immediately; first cycle after release is RUN.

Configuration
REQ-028 SHALL, with HAZARD_CTRL_DELAY_SLOT_EN defined, keep ifid_nop=0 on a committed branch (delay-slot instruction executes).
REQ-029 SHALL, without HAZARD_CTRL_DELAY_SLOT_EN, drive ifid_nop=1 whenever br_commit=1 (wrong-path fetch squashed).

Structure
REQ-030 SHALL place state encoding, RIDX_W default and NOP encoding 16'h0800 in shared package hazard_pkg.
REQ-031 SHALL contain one sub-module hazard_detect computing LU combinationally.

Verification
REQ-032 SHALL test load r2 in ID/EX, ID reads rs=2 -> one cycle pc_en=0, ifid_en=0, idex_bubble=1; next cycle all clear.
REQ-033 SHALL test hci_exmem_imem pulse, MEM_WAIT=3 -> stall=1 exactly 3 cycles, state MEMW 2 cycles, then pc_en=1.
REQ-034 SHALL test br_taken with no hazard -> br_commit=1, ifid_nop=1 (macro off) / 0 (macro on).
REQ-035 SHALL test br_taken coincident with LU -> br_commit=0 that cycle, br_commit=1 the following cycle.
REQ-036 SHALL test hci_rst low during MEMW cycle 2 -> outputs take reset values at once; after release no residual stall.
